// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: fixed-latency word fetch from a preloadable memory.
// It returns a response after WAIT_CYCLES of wait, supports abort, and flags bad addresses.
module inst_fetch_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_LOG2  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [31:0]           addr_i,
   input  logic                  abort_i,
   input  logic                  load_en_i,
   input  logic [DEPTH_LOG2-1:0] load_addr_i,
   input  logic [31:0]           load_data_i,
   output logic                  req_ready_o,
   output logic                  resp_valid_o,
   output logic [31:0]           resp_data_o,
   output logic                  resp_err_o,
   output logic                  freeze_o
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [31:0]           addr_q;
   logic [31:0]           data_q;
   logic                  err_q;
   logic [31:0]           mem [2**DEPTH_LOG2];

   logic [31:0]           rd_addr;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  rd_err;

   // With zero wait the RESP-entry edge is the accept edge, so look up the live address.
   always_comb begin
      rd_addr = (state_q == IDLE) ? addr_i : addr_q;
      rd_idx  = rd_addr[DEPTH_LOG2+1:2];
      rd_err  = (rd_addr[1:0] != 2'b00) || ((rd_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   end

   always_ff @(posedge clk_i) begin
      if (load_en_i && !rst_i) mem[load_addr_i] <= load_data_i;
   end

   // The memory read below samples mem before this edge's preload write lands.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i && !abort_i) begin
                  addr_q <= addr_i;
                  cnt_q  <= WAIT_INIT;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                     data_q  <= rd_err ? 32'd0 : mem[rd_idx];
                     err_q   <= rd_err;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (abort_i) begin
                  state_q <= IDLE;
               end else begin
                  if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_q <= RESP;
                     data_q  <= rd_err ? 32'd0 : mem[rd_idx];
                     err_q   <= rd_err;
                  end
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP) && !abort_i;
   assign freeze_o     = (state_q != IDLE) && !resp_valid_o && !abort_i;
   assign resp_data_o  = data_q;
   assign resp_err_o   = err_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances share stimulus,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_inst_fetch_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        abort = 1'b0;
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = 8'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] load_data = 32'd0;

   logic        rdy [2];
   logic        vld [2];
   logic        err [2];
   logic        frz [2];
   logic [31:0] dat [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_fetch_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) u_w2 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .abort_i(abort),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
      .req_ready_o(rdy[0]), .resp_valid_o(vld[0]), .resp_data_o(dat[0]),
      .resp_err_o(err[0]), .freeze_o(frz[0]));

   inst_fetch_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) u_w0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .abort_i(abort),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
      .req_ready_o(rdy[1]), .resp_valid_o(vld[1]), .resp_data_o(dat[1]),
      .resp_err_o(err[1]), .freeze_o(frz[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Transaction model: a fetch accepted in cycle c responds in cycle c+W+1.
   logic [31:0] mmem [256];
   bit          busy [2] = '{0, 0};
   int          due  [2] = '{0, 0};
   logic [31:0] maddr[2] = '{0, 0};
   logic [31:0] hdat [2] = '{0, 0};
   logic        herr [2] = '{0, 0};
   int          cyc = 0;
   bit          chk_on = 0;

   function automatic logic [32:0] lookup(input logic [31:0] a);
      logic e;
      e = (a[1:0] != 2'b00) || (a >= 32'd1024);
      return {e, e ? 32'd0 : mmem[a[9:2]]};
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int  w;
         bit  ev;
         logic [32:0] lk;
         w  = (k == 0) ? 2 : 0;
         ev = busy[k] && (cyc == due[k]) && !abort;
         if (chk_on) begin
            chk($sformatf("ready%0d", k),  {31'd0, rdy[k]}, {31'd0, !busy[k]});
            chk($sformatf("valid%0d", k),  {31'd0, vld[k]}, {31'd0, ev});
            chk($sformatf("freeze%0d", k), {31'd0, frz[k]}, {31'd0, busy[k] && !ev && !abort});
            chk($sformatf("data%0d", k),   dat[k], hdat[k]);
            chk($sformatf("err%0d", k),    {31'd0, err[k]}, {31'd0, herr[k]});
         end
         if (rst) begin
            busy[k] = 0;
            hdat[k] = 32'd0;
            herr[k] = 1'b0;
         end else if (busy[k]) begin
            if (abort || cyc == due[k]) busy[k] = 0;
            else if (cyc + 1 == due[k]) begin
               lk = lookup(maddr[k]);
               {herr[k], hdat[k]} = lk;
            end
         end else if (req && !abort) begin
            busy[k]  = 1;
            maddr[k] = addr;
            due[k]   = cyc + w + 1;
            if (w == 0) begin
               lk = lookup(addr);
               {herr[k], hdat[k]} = lk;
            end
         end
      end
      if (load_en && !rst) mmem[load_addr] = load_data;
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept on the next edge, then land #1 into the W=2 response cycle.
   task automatic fetch(input logic [31:0] a);
      req = 1'b1; addr = a;
      tick(); req = 1'b0;
      tick(); tick(); #1;
   endtask

   initial begin
      tick(); chk_on = 1;
      tick(); rst = 1'b0; #1;
      chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
      chk("rst_valid", {31'd0, vld[0]}, 32'd0);
      chk("rst_freeze", {31'd0, frz[0]}, 32'd0);
      chk("rst_data", dat[0], 32'd0);
      chk("rst_err", {31'd0, err[0]}, 32'd0);

      load_en = 1'b1; load_addr = 8'd4; load_data = 32'hE3A0_1005;
      tick(); load_addr = 8'd0; load_data = 32'h0000_1111;
      tick(); load_en = 1'b0;

      // Scenario 1 with a same-edge preload of the word being read.
      req = 1'b1; addr = 32'h10; #1;
      chk("s1_ready", {31'd0, rdy[0]}, 32'd1);
      tick(); req = 1'b0; #1;
      chk("s1_frz_w1", {31'd0, frz[0]}, 32'd1);
      chk("s1_vld_w1", {31'd0, vld[0]}, 32'd0);
      tick(); load_en = 1'b1; load_addr = 8'd4; load_data = 32'h1234_5678; #1;
      chk("s1_frz_w2", {31'd0, frz[0]}, 32'd1);
      tick(); load_en = 1'b0; #1;
      chk("s1_vld", {31'd0, vld[0]}, 32'd1);
      chk("s1_data", dat[0], 32'hE3A0_1005);
      chk("s1_err", {31'd0, err[0]}, 32'd0);
      chk("s1_frz_r", {31'd0, frz[0]}, 32'd0);
      tick();

      fetch(32'h10);
      chk("rbw_new_data", dat[0], 32'h1234_5678);
      tick();
      fetch(32'h12);
      chk("s2_vld", {31'd0, vld[0]}, 32'd1);
      chk("s2_err", {31'd0, err[0]}, 32'd1);
      chk("s2_data", dat[0], 32'd0);
      tick();
      fetch(32'h400);
      chk("s3_vld", {31'd0, vld[0]}, 32'd1);
      chk("s3_err", {31'd0, err[0]}, 32'd1);
      chk("s3_data", dat[0], 32'd0);
      tick();

      // Scenario 4: abort in the first WAIT cycle.
      req = 1'b1; addr = 32'h0;
      tick(); req = 1'b0; abort = 1'b1; #1;
      chk("s4_frz", {31'd0, frz[0]}, 32'd0);
      chk("s4_vld", {31'd0, vld[0]}, 32'd0);
      chk("s4_vld_w0", {31'd0, vld[1]}, 32'd0);
      tick(); abort = 1'b0; #1;
      chk("s4_ready", {31'd0, rdy[0]}, 32'd1);
      chk("s4_vld_after", {31'd0, vld[0]}, 32'd0);

      // Scenario 5: req held, W=0 instance alternates accept/resp.
      req = 1'b1; addr = 32'h0; #1;
      chk("s5_ready", {31'd0, rdy[1]}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick(); #1;
         chk($sformatf("s5_vld%0d", i), {31'd0, vld[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) chk($sformatf("s5_data%0d", i), dat[1], 32'h0000_1111);
      end
      req = 1'b0;
      repeat (5) tick();

      // Scenario 6: reset mid-fetch, memory survives reset, load ignored under reset.
      req = 1'b1; addr = 32'h10;
      tick(); req = 1'b0; rst = 1'b1;
      tick(); rst = 1'b0; #1;
      chk("s6_ready", {31'd0, rdy[0]}, 32'd1);
      chk("s6_vld", {31'd0, vld[0]}, 32'd0);
      chk("s6_data", dat[0], 32'd0);
      chk("s6_err", {31'd0, err[0]}, 32'd0);
      load_en = 1'b1; load_addr = 8'd8; load_data = 32'hA5A5_A5A5;
      tick(); rst = 1'b1; load_data = 32'hDEAD_BEEF;
      tick(); rst = 1'b0; load_en = 1'b0;
      fetch(32'h20);
      chk("s6_vld2", {31'd0, vld[0]}, 32'd1);
      chk("s6_keep", dat[0], 32'hA5A5_A5A5);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
